// File: rtl/pio_pkg.sv
// Shared definitions for the PIO configuration sequencer.
//   pio_act_e   : action codes presented on pio_action
//   pio_state_e : sequencer FSM states
package pio_pkg;

    typedef enum logic [3:0] {
        ACT_NONE  = 4'd0,
        ACT_INSTR = 4'd1,
        ACT_PEND  = 4'd2,
        ACT_PULL  = 4'd3,
        ACT_PUSH  = 4'd4,
        ACT_GRPS  = 4'd5,
        ACT_EN    = 4'd6,
        ACT_DIV   = 4'd7,
        ACT_SIDES = 4'd8,
        ACT_SHIFT = 4'd10
    } pio_act_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PEND,
        ST_DIV,
        ST_GRPS,
        ST_SIDES,
        ST_SHIFT,
        ST_EN,
        ST_RUN,
        ST_STOP
    } pio_state_e;

endpackage

// File: rtl/pio_seq_rr.sv
// Two-way round-robin arbiter between the TX (PUSH) and RX (PULL) paths.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_tx, req_rx      : paths that want the PIO this cycle
//   served_tx/served_rx : an action was actually issued for that path
//   gnt_tx, gnt_rx      : path holds the grant (uncontested or its turn)
// After serving one path, priority moves to the other; TX has priority
// out of reset.
module pio_seq_rr (
    input  logic clk,
    input  logic reset,
    input  logic req_tx,
    input  logic req_rx,
    input  logic served_tx,
    input  logic served_rx,
    output logic gnt_tx,
    output logic gnt_rx
);

    logic prio_rx;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_rx <= 1'b0;
        end else if (served_tx) begin
            prio_rx <= 1'b1;
        end else if (served_rx) begin
            prio_rx <= 1'b0;
        end
    end

    // Grant does not depend on the path's own request so tx_ready can be
    // offered before tx_valid arrives.
    assign gnt_tx = !req_rx || !prio_rx;
    assign gnt_rx = !req_tx || prio_rx;

endmodule

// File: rtl/pio_seq.sv
// PIO state-machine configuration sequencer and TX/RX data pump.
// Loads a program, writes the machine config registers, enables the machine,
// then moves TX stream words into the PIO (PUSH) and PIO words out to the RX
// stream (PULL) until stopped.
// Build option: PIO_SEQ_RX_EN -- when undefined the RX/PULL path is absent,
// rx_valid/rx_data are tied low and TX always holds the grant.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   start, stop                : begin configuration / disable running machine
//   cfg_*                      : configuration, sampled on an accepted start
//   prog_addr, prog_data       : program memory read, 1-cycle latency
//   pio_action/index/mindex/din: action issued to the PIO block
//   pio_dout, pio_full/empty   : PIO read data and per-machine FIFO status
//   tx_*, rx_*                 : valid/ready streams
//   busy, cfg_done, err        : status (cfg_done is a pulse, err sticky)
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | one INSTR per cycle, program memory read one address ahead
// PEND   | write program end address (plen-1)
// DIV    | write clock divider
// GRPS   | write pin groups
// SIDES  | write side-set config
// SHIFT  | write shift control
// EN     | enable machine (din=1)
// RUN    | arbitrate PUSH/PULL traffic
// STOP   | disable machine (din=0), back to IDLE
module pio_seq #(
    parameter int SM_W       = 2,
    parameter int PROG_DEPTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic [5:0]      cfg_plen,
    input  logic [SM_W-1:0] cfg_sm,
    input  logic [23:0]     cfg_div,
    input  logic [31:0]     cfg_grps,
    input  logic [5:0]      cfg_sides,
    input  logic [31:0]     cfg_shift,
    output logic [4:0]      prog_addr,
    input  logic [15:0]     prog_data,
    output logic [3:0]      pio_action,
    output logic [4:0]      pio_index,
    output logic [SM_W-1:0] pio_mindex,
    output logic [31:0]     pio_din,
    input  logic [31:0]     pio_dout,
    input  logic [3:0]      pio_full,
    input  logic [3:0]      pio_empty,
    input  logic [31:0]     tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic [31:0]     rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            busy,
    output logic            cfg_done,
    output logic            err
);

    import pio_pkg::*;

    localparam logic [6:0] DEPTH_MAX = 7'(PROG_DEPTH);

    pio_state_e      state_q, state_d;
    pio_act_e        act;
    logic [5:0]      plen_q;
    logic [SM_W-1:0] sm_q;
    logic [23:0]     div_q;
    logic [31:0]     grps_q;
    logic [5:0]      sides_q;
    logic [31:0]     shift_q;
    logic [5:0]      cnt_q;
    logic            err_q, done_q, guard_q;
    logic            plen_bad;
    logic            tx_req, rx_req, gnt_tx, gnt_rx, push, pull;

    assign plen_bad = (cfg_plen == 6'd0) || ({1'b0, cfg_plen} > DEPTH_MAX);
    assign tx_req   = tx_valid && !pio_full[sm_q];

    pio_seq_rr u_rr (
        .clk       (clk),
        .reset     (reset),
        .req_tx    (tx_req),
        .req_rx    (rx_req),
        .served_tx (push),
        .served_rx (pull),
        .gnt_tx    (gnt_tx),
        .gnt_rx    (gnt_rx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            plen_q  <= 6'd0;
            sm_q    <= '0;
            div_q   <= 24'd0;
            grps_q  <= 32'd0;
            sides_q <= 6'd0;
            shift_q <= 32'd0;
            cnt_q   <= 6'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == ST_LOAD) ? cnt_q + 6'd1 : 6'd0;
            guard_q <= push || pull;
            done_q  <= (state_q == ST_EN);
            if (start && state_q == ST_IDLE) begin
                err_q <= plen_bad;
                if (!plen_bad) begin
                    plen_q  <= cfg_plen;
                    sm_q    <= cfg_sm;
                    div_q   <= cfg_div;
                    grps_q  <= cfg_grps;
                    sides_q <= cfg_sides;
                    shift_q <= cfg_shift;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        act       = ACT_NONE;
        pio_din   = 32'd0;
        pio_index = 5'd0;
        prog_addr = 5'd0;
        tx_ready  = 1'b0;
        push      = 1'b0;
        pull      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // prog_addr sits at 0 here, so word 0 is ready on LOAD entry.
                if (start && !plen_bad) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                act       = ACT_INSTR;
                pio_index = cnt_q[4:0];
                pio_din   = {16'h0, prog_data};
                prog_addr = cnt_q[4:0] + 5'd1;
                if (cnt_q == plen_q - 6'd1) state_d = ST_PEND;
            end
            ST_PEND: begin
                act     = ACT_PEND;
                pio_din = {26'h0, plen_q - 6'd1};
                state_d = ST_DIV;
            end
            ST_DIV: begin
                act     = ACT_DIV;
                pio_din = {8'h0, div_q};
                state_d = ST_GRPS;
            end
            ST_GRPS: begin
                act     = ACT_GRPS;
                pio_din = grps_q;
                state_d = ST_SIDES;
            end
            ST_SIDES: begin
                act     = ACT_SIDES;
                pio_din = {26'h0, sides_q};
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                act     = ACT_SHIFT;
                pio_din = shift_q;
                state_d = ST_EN;
            end
            ST_EN: begin
                act     = ACT_EN;
                pio_din = 32'd1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_STOP;
                end else if (!guard_q) begin
                    tx_ready = gnt_tx && !pio_full[sm_q];
                    if (tx_ready && tx_valid) begin
                        push    = 1'b1;
                        act     = ACT_PUSH;
                        pio_din = tx_data;
                    end else if (rx_req && gnt_rx) begin
                        pull = 1'b1;
                        act  = ACT_PULL;
                    end
                end
            end
            ST_STOP: begin
                act     = ACT_EN;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PIO_SEQ_RX_EN
    logic        pull_q, rx_valid_q;
    logic [31:0] rx_data_q;

    // PIO returns read data the cycle after PULL; the capture completes even
    // if stop arrives in between.
    always_ff @(posedge clk) begin
        if (reset) begin
            pull_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 32'd0;
        end else begin
            pull_q <= pull;
            if (pull_q) begin
                rx_data_q  <= pio_dout;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_req   = !pio_empty[sm_q] && !rx_valid_q && !pull_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
`else
    logic unused_rx;

    assign rx_req    = 1'b0;
    assign rx_valid  = 1'b0;
    assign rx_data   = 32'd0;
    assign unused_rx = ^{rx_ready, pio_dout, pio_empty};
`endif

    assign pio_action = act;
    assign pio_mindex = sm_q;
    assign busy       = (state_q != ST_IDLE);
    assign cfg_done   = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pio_seq.sv
// Bench for pio_seq: directed configuration scenarios plus randomized RUN
// traffic compared against a cycle-level behavioural model of the PUSH/PULL
// rules (guard cycle, alternating priority, RX capture one cycle after PULL).
module tb_pio_seq;

`ifdef PIO_SEQ_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stop;
    logic [5:0]  cfg_plen;
    logic [1:0]  cfg_sm;
    logic [23:0] cfg_div;
    logic [31:0] cfg_grps;
    logic [5:0]  cfg_sides;
    logic [31:0] cfg_shift;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [3:0]  pio_action;
    logic [4:0]  pio_index;
    logic [1:0]  pio_mindex;
    logic [31:0] pio_din, pio_dout;
    logic [3:0]  pio_full, pio_empty;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready;
    logic        busy, cfg_done, err;

    pio_seq #(.SM_W(2), .PROG_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cfg_plen(cfg_plen), .cfg_sm(cfg_sm), .cfg_div(cfg_div),
        .cfg_grps(cfg_grps), .cfg_sides(cfg_sides), .cfg_shift(cfg_shift),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .pio_action(pio_action), .pio_index(pio_index), .pio_mindex(pio_mindex),
        .pio_din(pio_din), .pio_dout(pio_dout), .pio_full(pio_full),
        .pio_empty(pio_empty), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .busy(busy), .cfg_done(cfg_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] prog_mem [32];

    // behavioural model state
    logic [1:0]  m_sm;
    bit          m_turn_rx, m_guard, m_done, m_rx_valid, m_cap_pending;
    logic [31:0] m_rx_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_sm = 2'd0; m_turn_rx = 0; m_guard = 0; m_done = 0;
        m_rx_valid = 0; m_cap_pending = 0; m_rx_data = 32'd0;
    endtask

    // Close the current cycle: advance RX model on pre-edge inputs, clock,
    // then present program memory data for the address seen before the edge.
    task automatic cycle_end(input bit pulled);
        logic [4:0] a;
        a = prog_addr;
        if (m_cap_pending) begin
            m_rx_valid = 1;
            m_rx_data  = pio_dout;
        end else if (m_rx_valid && rx_ready) begin
            m_rx_valid = 0;
        end
        m_cap_pending = pulled;
        @(posedge clk);
        #1;
        prog_data = prog_mem[a];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_act"},   32'(pio_action), 32'd0);
        check({tag, "_idx"},   32'(pio_index),  32'd0);
        check({tag, "_midx"},  32'(pio_mindex), 32'd0);
        check({tag, "_din"},   pio_din,         32'd0);
        check({tag, "_addr"},  32'(prog_addr),  32'd0);
        check({tag, "_txrdy"}, 32'(tx_ready),   32'd0);
        check({tag, "_rxv"},   32'(rx_valid),   32'd0);
        check({tag, "_rxd"},   rx_data,         32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(cfg_done),   32'd0);
        check({tag, "_err"},   32'(err),        32'd0);
    endtask

    task automatic bad_start(input logic [5:0] plen);
        cfg_plen = plen;
        start = 1;
        #2;
        cycle_end(0);
        start = 0;
        repeat (3) begin
            #2;
            check("bad_err",  32'(err),        32'd1);
            check("bad_act",  32'(pio_action), 32'd0);
            check("bad_busy", 32'(busy),       32'd0);
            cycle_end(0);
        end
    endtask

    task automatic do_config(input logic [5:0] plen, input logic [1:0] sm,
                             input logic [23:0] div, input logic [31:0] grps,
                             input logic [5:0] sides, input logic [31:0] shift,
                             input bit poke_start);
        logic [3:0]  e_act;
        logic [4:0]  e_idx;
        logic [31:0] e_din;
        int j;
        tx_valid  = 0;
        pio_empty = 4'hF;
        cfg_plen = plen; cfg_sm = sm; cfg_div = div;
        cfg_grps = grps; cfg_sides = sides; cfg_shift = shift;
        start = 1;
        #2;
        check("cfg_idle_busy", 32'(busy), 32'd0);
        cycle_end(0);
        start = 0;
        // config must have been sampled at the accepted start
        cfg_plen = 6'($urandom); cfg_sm = 2'($urandom); cfg_div = 24'($urandom);
        cfg_grps = $urandom; cfg_sides = 6'($urandom); cfg_shift = $urandom;
        for (int k = 0; k < int'(plen) + 6; k++) begin
            start = (poke_start && k == 1);
            #2;
            e_idx = 5'd0;
            if (k < int'(plen)) begin
                e_act = 4'd1;
                e_idx = 5'(k);
                e_din = {16'h0, prog_mem[k]};
            end else begin
                j = k - int'(plen);
                case (j)
                    0:       begin e_act = 4'd2;  e_din = 32'(plen) - 32'd1; end
                    1:       begin e_act = 4'd7;  e_din = {8'h0, div}; end
                    2:       begin e_act = 4'd5;  e_din = grps; end
                    3:       begin e_act = 4'd8;  e_din = {26'h0, sides}; end
                    4:       begin e_act = 4'd10; e_din = shift; end
                    default: begin e_act = 4'd6;  e_din = 32'd1; end
                endcase
            end
            check("cfg_act",  32'(pio_action), 32'(e_act));
            check("cfg_idx",  32'(pio_index),  32'(e_idx));
            check("cfg_din",  pio_din,         e_din);
            check("cfg_midx", 32'(pio_mindex), 32'(sm));
            check("cfg_busy", 32'(busy),       32'd1);
            check("cfg_done_early", 32'(cfg_done), 32'd0);
            if (k == 0) check("cfg_err_clear", 32'(err), 32'd0);
            cycle_end(0);
        end
        start = 0;
        m_sm = sm; m_guard = 0; m_done = 1;
    endtask

    // One RUN cycle with caller-set inputs, checked against the model.
    task automatic step_run(input bit stop_now);
        bit tx_ok, rx_want, active, e_ready, e_push, e_pull;
        logic [3:0]  e_act;
        logic [31:0] e_din;
        stop = stop_now;
        #2;
        tx_ok   = !pio_full[m_sm];
        rx_want = RX_EN && !pio_empty[m_sm] && !m_rx_valid && !m_cap_pending;
        active  = !m_guard && !stop_now;
        e_ready = active && tx_ok && !(rx_want && m_turn_rx);
        e_push  = e_ready && tx_valid;
        e_pull  = active && rx_want && !e_push;
        e_act   = e_push ? 4'd4 : (e_pull ? 4'd3 : 4'd0);
        e_din   = e_push ? tx_data : 32'd0;
        check("run_act",   32'(pio_action), 32'(e_act));
        check("run_din",   pio_din,         e_din);
        check("run_txrdy", 32'(tx_ready),   32'(e_ready));
        check("run_rxv",   32'(rx_valid),   32'(m_rx_valid));
        if (m_rx_valid) check("run_rxd", rx_data, m_rx_data);
        check("run_done",  32'(cfg_done),   32'(m_done));
        check("run_busy",  32'(busy),       32'd1);
        check("run_midx",  32'(pio_mindex), 32'(m_sm));
        if (e_push) m_turn_rx = 1;
        if (e_pull) m_turn_rx = 0;
        m_done  = 0;
        m_guard = e_push || e_pull;
        cycle_end(e_pull);
        stop = 0;
    endtask

    task automatic do_stop();
        step_run(1);
        #2;
        check("stop_act",   32'(pio_action), 32'd6);
        check("stop_din",   pio_din,         32'd0);
        check("stop_busy",  32'(busy),       32'd1);
        check("stop_txrdy", 32'(tx_ready),   32'd0);
        cycle_end(0);
        #2;
        check("stopped_busy", 32'(busy),       32'd0);
        check("stopped_act",  32'(pio_action), 32'd0);
        check("stopped_rxv",  32'(rx_valid),   32'(m_rx_valid));
        cycle_end(0);
    endtask

    task automatic randomize_run_inputs();
        tx_valid  = ($urandom_range(3, 0) != 0);
        tx_data   = $urandom;
        pio_full  = 4'($urandom) & 4'($urandom);
        pio_empty = 4'($urandom);
        pio_dout  = $urandom;
        rx_ready  = 1'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) prog_mem[i] = 16'($urandom);
        reset = 1; start = 0; stop = 0;
        cfg_plen = 6'd0; cfg_sm = 2'd0; cfg_div = 24'd0; cfg_grps = 32'd0;
        cfg_sides = 6'd0; cfg_shift = 32'd0; prog_data = 16'd0;
        pio_dout = 32'd0; pio_full = 4'h0; pio_empty = 4'hF;
        tx_data = 32'd0; tx_valid = 0; rx_ready = 0;
        model_reset();
        cycle_end(0);
        cycle_end(0);
        reset = 0;
        model_reset();
        #2;
        check_all_zero("rst");
        cycle_end(0);

        bad_start(6'd0);

        do_config(6'd2, 2'd0, 24'h000C80, 32'h20100001, 6'h21, 32'h10830000, 0);
        step_run(0);

        tx_valid = 1; tx_data = 32'h40000000; pio_full = 4'h0; pio_empty = 4'hF;
        step_run(0);
        tx_valid = 0;
        step_run(0);

        pio_full = 4'h1; tx_valid = 1; tx_data = $urandom;
        pio_empty = 4'hE; pio_dout = 32'h5A; rx_ready = 0;
        repeat (5) step_run(0);
        pio_empty = 4'hF; rx_ready = 1;
        repeat (2) step_run(0);

        pio_full = 4'h0; tx_valid = 1; pio_empty = 4'hE; rx_ready = 1;
        repeat (12) begin
            tx_data = $urandom; pio_dout = $urandom;
            step_run(0);
        end

        repeat (200) begin
            randomize_run_inputs();
            step_run(0);
        end
        do_stop();

        bad_start(6'd33);

        do_config(6'd32, 2'($urandom), 24'($urandom), $urandom, 6'($urandom), $urandom, 1);
        repeat (150) begin
            randomize_run_inputs();
            step_run(0);
        end
        do_stop();

        do_config(6'($urandom_range(31, 1)), 2'($urandom), 24'($urandom), $urandom,
                  6'($urandom), $urandom, 0);
        repeat (100) begin
            randomize_run_inputs();
            step_run(0);
        end
        do_stop();

        cfg_plen = 6'd20; start = 1;
        #2;
        cycle_end(0);
        start = 0;
        repeat (3) cycle_end(0);
        #2;
        check("load_busy", 32'(busy), 32'd1);
        reset = 1;
        cycle_end(0);
        reset = 0;
        model_reset();
        #2;
        check_all_zero("rst_load");
        cycle_end(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
